// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the instruction and data caches.
//   CACHE_ADDR_W / CACHE_DATA_W : default byte-address and word widths
//   ic_state_t                  : instruction-cache controller states
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_t;

endpackage

// File: rtl/icache_direct_mapped_if.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped_if
// Bundles the fetch-side and memory-side signals of the instruction cache.
//   rd_en, addr, flush      : fetch request / invalidate-all
//   data, valid, stall      : fetch response and miss stall
//   mem_req, mem_addr       : word read request to instruction memory
//   mem_data, mem_valid     : returned word from instruction memory
// Modports:
//   slave  : the cache itself
//   master : the surrounding fetch stage plus memory (or a testbench)
// -----------------------------------------------------------------------------
interface icache_direct_mapped_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic              flush;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;

  modport slave (
    input  rd_en, addr, flush, mem_data, mem_valid,
    output data, valid, stall, mem_req, mem_addr
  );

  modport master (
    output rd_en, addr, flush, mem_data, mem_valid,
    input  data, valid, stall, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_data_array.sv
// -----------------------------------------------------------------------------
// icache_data_array
// Instruction storage: (2**IDX_W) lines x (2**OFF_W) words x DATA_W bits.
//   clk                     : write clock
//   rd_idx, rd_off, rd_data : asynchronous read port
//   we, wr_idx, wr_off, wr_data : synchronous write port
// Contents are not reset; the tag/valid state in the top decides whether a
// word may be used.
// -----------------------------------------------------------------------------
module icache_data_array
  import cache_pkg::*;
#(
  parameter int DATA_W = CACHE_DATA_W,
  parameter int IDX_W  = 4,
  parameter int OFF_W  = 2
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_r [2**IDX_W][2**OFF_W];

  assign rd_data = mem_r[rd_idx][rd_off];

  // Refill beat write into the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped
// Direct-mapped read-only instruction cache between fetch and instruction
// memory. Hits return data in the same cycle; a miss stalls fetch while the
// line is refilled one word per memory beat, after which the held fetch hits.
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : icache_direct_mapped_if.slave (fetch + memory signals)
// -----------------------------------------------------------------------------
module icache_direct_mapped
  import cache_pkg::*;
#(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int DATA_W     = CACHE_DATA_W,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  icache_direct_mapped_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  ic_state_t            state_r;
  ic_state_t            state_nxt_s;
  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] valid_nxt_s;
  logic [TAG_W-1:0]     tag_arr_r [NUM_LINES];
  logic [TAG_W-1:0]     miss_tag_r;
  logic [IDX_W-1:0]     miss_idx_r;
  logic [OFF_W-1:0]     cnt_r;
  logic                 abort_r;

  logic [TAG_W-1:0]     tag_s;
  logic [IDX_W-1:0]     idx_s;
  logic [OFF_W-1:0]     off_s;
  logic                 hit_s;
  logic [DATA_W-1:0]    rd_data_s;
  logic                 beat_s;
  logic                 last_beat_s;
  logic                 start_miss_s;
  logic                 addr_unused_s;

  assign tag_s = bus.addr[ADDR_W-1 -: TAG_W];
  assign idx_s = bus.addr[2+OFF_W +: IDX_W];
  assign off_s = bus.addr[2 +: OFF_W];
  // Byte offset within a word is irrelevant to word-aligned fetch.
  assign addr_unused_s = ^bus.addr[1:0];

  assign hit_s        = valid_r[idx_s] & (tag_arr_r[idx_s] == tag_s);
  assign beat_s       = (state_r == IC_REFILL) & bus.mem_valid & ~rst_i;
  assign last_beat_s  = beat_s & (cnt_r == LAST_OFF);
  assign start_miss_s = (state_r == IC_IDLE) & bus.rd_en & ~hit_s & ~rst_i;

  icache_data_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W)
  ) u_data_array (
    .clk     (clk_i),
    .rd_idx  (idx_s),
    .rd_off  (off_s),
    .rd_data (rd_data_s),
    .we      (beat_s),
    .wr_idx  (miss_idx_r),
    .wr_off  (cnt_r),
    .wr_data (bus.mem_data)
  );

  // Next valid vector: flush clears everything, then a completing refill
  // marks its line valid unless a flush arrived during (or on) the refill.
  always_comb begin
    valid_nxt_s = valid_r;
    if (bus.flush) begin
      valid_nxt_s = '0;
    end else begin
      valid_nxt_s = valid_r;
    end
    if (last_beat_s) begin
      valid_nxt_s[miss_idx_r] = ~(abort_r | bus.flush);
    end else begin
      valid_nxt_s[miss_idx_r] = valid_nxt_s[miss_idx_r];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IC_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Miss bookkeeping: latched miss address, beat counter, abort flag, valid bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r    <= '0;
      miss_tag_r <= '0;
      miss_idx_r <= '0;
      cnt_r      <= '0;
      abort_r    <= 1'b0;
    end else begin
      valid_r <= valid_nxt_s;
      if (start_miss_s) begin
        miss_tag_r <= tag_s;
        miss_idx_r <= idx_s;
        cnt_r      <= '0;
        abort_r    <= 1'b0;
      end else if (state_r == IC_REFILL) begin
        if (beat_s) begin
          cnt_r <= cnt_r + OFF_W'(1);
        end
        abort_r <= last_beat_s ? 1'b0 : (abort_r | bus.flush);
      end
    end
  end

  // Tag written once the whole line has arrived; gated by valid, so no reset
  always_ff @(posedge clk_i) begin
    if (last_beat_s) begin
      tag_arr_r[miss_idx_r] <= miss_tag_r;
    end
  end

  // Next-state and outputs; everything is forced quiet during reset
  always_comb begin
    state_nxt_s  = state_r;
    bus.data     = '0;
    bus.valid    = 1'b0;
    bus.stall    = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    if (rst_i) begin
      state_nxt_s = IC_IDLE;
    end else begin
      case (state_r)
        IC_IDLE: begin
          if (bus.rd_en) begin
            if (hit_s) begin
              bus.valid   = 1'b1;
              bus.data    = rd_data_s;
              state_nxt_s = IC_IDLE;
            end else begin
              bus.stall   = 1'b1;
              state_nxt_s = IC_REFILL;
            end
          end else begin
            state_nxt_s = IC_IDLE;
          end
        end
        IC_REFILL: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = {miss_tag_r, miss_idx_r, cnt_r, 2'b00};
          bus.stall    = 1'b1;
          if (last_beat_s) begin
            state_nxt_s = IC_IDLE;
          end else begin
            state_nxt_s = IC_REFILL;
          end
        end
        default: begin
          state_nxt_s = IC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// tb_icache_direct_mapped
// Self-checking bench for icache_direct_mapped. A small memory model answers
// refill requests; expected refill addresses and fetch data are queued when
// stimulus is driven and popped when the cache responds.
// -----------------------------------------------------------------------------
module tb_icache_direct_mapped;
  import cache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_direct_mapped_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  icache_direct_mapped #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LINE_WORDS (4),
    .NUM_LINES  (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  // Memory contents: line 0x40 holds 0xA0..0xA3, other lines differ by tag/index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + {28'h0, a[5:2]} + (({22'h0, a[15:6]} - 32'd1) << 8);
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One miss on address a: checks the miss cycle, every refill request, and
  // the cycle after the final beat (hit if exp_hit, otherwise a repeat miss).
  // flush_beat / rst_beat select a beat (0..3) for a flush / reset, -1 for none.
  task automatic refill_line(input logic [31:0] a, input int gap,
                             input int flush_beat, input int rst_beat,
                             input bit exp_hit);
    logic [31:0] ea;
    logic [31:0] ed;
    bus.rd_en = 1'b1;
    bus.addr  = a;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back({a[31:4], 4'h0} + 32'(4 * i));
    smp();
    n_tests++;
    if (bus.stall !== 1'b1 || bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_detect addr=%h stall=%b valid=%b required stall=1 valid=0",
               a, bus.stall, bus.valid);
    end
    go();
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        smp();
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.stall !== 1'b1 || bus.valid !== 1'b0 ||
            bus.mem_addr !== exp_addr_q[0]) begin
          n_fail++;
          $display("FAIL refill_wait addr=%h mem_req=%b stall=%b valid=%b mem_addr=%h required 1 1 0 %h",
                   a, bus.mem_req, bus.stall, bus.valid, bus.mem_addr, exp_addr_q[0]);
        end
        go();
      end
      ea = exp_addr_q.pop_front();
      bus.mem_valid = 1'b1;
      bus.mem_data  = mem_word(ea);
      bus.flush     = (b == flush_beat);
      if (b == rst_beat) begin
        rst = 1'b1;
        bus.rd_en = 1'b0;
      end
      smp();
      n_tests++;
      if (b == rst_beat) begin
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_cycle_outputs mem_req=%b stall=%b required 0 0",
                   bus.mem_req, bus.stall);
        end
      end else if (bus.mem_req !== 1'b1 || bus.stall !== 1'b1 || bus.mem_addr !== ea) begin
        n_fail++;
        $display("FAIL refill_beat beat=%0d mem_req=%b stall=%b mem_addr=%h required 1 1 %h",
                 b, bus.mem_req, bus.stall, bus.mem_addr, ea);
      end
      go();
      bus.mem_valid = 1'b0;
      bus.flush     = 1'b0;
      if (b == rst_beat) begin
        rst = 1'b0;
        exp_addr_q.delete();
        smp();
        n_tests++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.valid !== 1'b0) begin
          n_fail++;
          $display("FAIL after_reset_abort mem_req=%b stall=%b valid=%b required 0 0 0",
                   bus.mem_req, bus.stall, bus.valid);
        end
        go();
        return;
      end
    end
    exp_data_q.push_back(mem_word(a));
    smp();
    ed = exp_data_q.pop_front();
    n_tests++;
    if (exp_hit) begin
      if (bus.valid !== 1'b1 || bus.data !== ed || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL replay_hit addr=%h valid=%b data=%h stall=%b mem_req=%b required 1 %h 0 0",
                 a, bus.valid, bus.data, bus.stall, bus.mem_req, ed);
      end
    end else begin
      if (bus.valid !== 1'b0 || bus.stall !== 1'b1 || bus.data !== 32'h0) begin
        n_fail++;
        $display("FAIL aborted_line_misses addr=%h valid=%b stall=%b data=%h required 0 1 0",
                 a, bus.valid, bus.stall, bus.data);
      end
    end
    bus.rd_en = 1'b0;
    go();
  endtask

  task automatic test_reset();
    bus.rd_en = 1'b1; bus.addr = 32'h40; bus.flush = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_data = 32'h0;
    smp();
    n_tests++;
    if (bus.data !== 32'h0 || bus.valid !== 1'b0 || bus.stall !== 1'b0 ||
        bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs data=%h valid=%b stall=%b mem_req=%b mem_addr=%h required all 0",
               bus.data, bus.valid, bus.stall, bus.mem_req, bus.mem_addr);
    end
    go();
    rst = 1'b0;
    bus.rd_en = 1'b0;
    smp();
    n_tests++;
    if (bus.valid !== 1'b0 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset valid=%b stall=%b mem_req=%b required 0 0 0",
               bus.valid, bus.stall, bus.mem_req);
    end
    go();
  endtask

  task automatic test_cold_miss();
    refill_line(32'h40, 1, -1, -1, 1'b1);
  endtask

  task automatic test_hit();
    logic [31:0] a;
    logic [31:0] ed;
    for (int i = 3; i >= 0; i--) begin
      a = 32'h40 + 32'(4 * i);
      bus.rd_en = 1'b1; bus.addr = a;
      exp_data_q.push_back(mem_word(a));
      smp();
      ed = exp_data_q.pop_front();
      n_tests++;
      if (bus.valid !== 1'b1 || bus.data !== ed || bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL hit addr=%h valid=%b data=%h stall=%b mem_req=%b required 1 %h 0 0",
                 a, bus.valid, bus.data, bus.stall, bus.mem_req, ed);
      end
      go();
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_mem_valid_idle();
    logic [31:0] ed;
    bus.rd_en = 1'b0; bus.mem_valid = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
    go(); go();
    bus.mem_valid = 1'b0;
    bus.rd_en = 1'b1; bus.addr = 32'h44;
    exp_data_q.push_back(mem_word(32'h44));
    smp();
    ed = exp_data_q.pop_front();
    n_tests++;
    if (bus.valid !== 1'b1 || bus.data !== ed || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_mem_valid valid=%b data=%h mem_req=%b required 1 %h 0",
               bus.valid, bus.data, bus.mem_req, ed);
    end
    bus.rd_en = 1'b0;
    go();
  endtask

  task automatic test_conflict();
    refill_line(32'h440, 1, -1, -1, 1'b1);
    refill_line(32'h40, 1, -1, -1, 1'b1);
    refill_line(32'h440, 0, -1, -1, 1'b1);
  endtask

  task automatic test_flush_idle();
    logic [31:0] ed;
    bus.rd_en = 1'b1; bus.addr = 32'h448; bus.flush = 1'b1;
    exp_data_q.push_back(mem_word(32'h448));
    smp();
    ed = exp_data_q.pop_front();
    n_tests++;
    if (bus.valid !== 1'b1 || bus.data !== ed) begin
      n_fail++;
      $display("FAIL flush_cycle_lookup valid=%b data=%h required 1 %h", bus.valid, bus.data, ed);
    end
    bus.rd_en = 1'b0;
    go();
    bus.flush = 1'b0;
    refill_line(32'h440, 1, -1, -1, 1'b1);
  endtask

  task automatic test_flush_refill();
    refill_line(32'h80, 1, 2, -1, 1'b0);
    refill_line(32'h80, 1, -1, -1, 1'b1);
  endtask

  task automatic test_flush_last_beat();
    refill_line(32'hC0, 0, 3, -1, 1'b0);
    refill_line(32'hC0, 0, -1, -1, 1'b1);
  endtask

  task automatic test_reset_refill();
    refill_line(32'h100, 1, -1, -1, 1'b1);
    refill_line(32'h40, 1, -1, 1, 1'b0);
    refill_line(32'h100, 1, -1, -1, 1'b1);
    refill_line(32'hC0, 0, -1, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_mem_valid_idle();
    test_conflict();
    test_flush_idle();
    test_flush_refill();
    test_flush_last_beat();
    test_reset_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
